key_debounce_pulse: RTL and testbench



---
 rtl/key_debounce_pkg.sv | 14 +
 rtl/key_debounce_ch.sv | 117 +++++++++++
 rtl/key_debounce_pulse.sv | 44 ++++
 tb/tb_key_debounce_pulse.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared channel state encoding and reset constants for key_debounce_pulse.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } key_state_t;

    // Synchroniser flops reset to the released (high) key level.
    localparam logic SYNC_RESET_VAL = 1'b1;

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel - 2-flop synchroniser, debounce FSM, optional auto-repeat.
// Define AUTO_REPEAT_EN to add the held-key repeat counter.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    key_state_t state;
    logic [CNT_W-1:0] cnt;
    logic sync1;
    logic sync2;
    logic s;

    assign s = ~sync2;

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rcnt;
    logic repeating;
    logic [REP_W-1:0] rep_limit;

    // First repeat waits the long delay, later ones the shorter period.
    assign rep_limit = repeating ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= SYNC_RESET_VAL;
            sync2 <= SYNC_RESET_VAL;
            state <= IDLE;
            cnt <= '0;
            key_level <= 1'b0;
            key_press <= 1'b0;
            key_release <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rcnt <= '0;
            repeating <= 1'b0;
`endif
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            key_press <= 1'b0;
            key_release <= 1'b0;
            case (state)
                IDLE: begin
                    if (s) begin
                        state <= PRESS_WAIT;
                        cnt <= '0;
                    end
`ifdef AUTO_REPEAT_EN
                    rcnt <= '0;
                    repeating <= 1'b0;
`endif
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state <= IDLE;
                    end else if (cnt == CNT_MAX) begin
                        state <= HELD;
                        key_press <= 1'b1;
                        key_level <= 1'b1;
`ifdef AUTO_REPEAT_EN
                        rcnt <= '0;
                        repeating <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state <= RELEASE_WAIT;
                        cnt <= '0;
`ifdef AUTO_REPEAT_EN
                    end else if (rcnt == rep_limit) begin
                        key_press <= 1'b1;
                        rcnt <= '0;
                        repeating <= 1'b1;
                    end else begin
                        rcnt <= rcnt + 1'b1;
`endif
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state <= HELD;
                    end else if (cnt == CNT_MAX) begin
                        state <= IDLE;
                        key_release <= 1'b1;
                        key_level <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: debounced level and press/release pulses for KEY_WIDTH active-low keys.
// Define AUTO_REPEAT_EN to make held keys emit repeated key_press pulses.
module key_debounce_pulse
    import key_debounce_pkg::*;
#(
    parameter int KEY_WIDTH       = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [KEY_WIDTH-1:0] key_n,
    output logic [KEY_WIDTH-1:0] key_level,
    output logic [KEY_WIDTH-1:0] key_press,
    output logic [KEY_WIDTH-1:0] key_release,
    output logic                 any_press
);
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("key_debounce_pulse: illegal timing parameters");
    end

    for (genvar i = 0; i < KEY_WIDTH; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef AUTO_REPEAT_EN
            ,
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk(clk),
            .rst(rst),
            .key_n(key_n[i]),
            .key_level(key_level[i]),
            .key_press(key_press[i]),
            .key_release(key_release[i])
        );
    end

    // Registered pulses ORed together: one enable cycle even for simultaneous presses.
    assign any_press = |key_press;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// tb_key_debounce_pulse: table vectors, directed corner sequences and random keys vs a run-length model.
module tb_key_debounce_pulse;
    localparam int W = 4;
    localparam int D = 8;
    localparam int RD = 20;
    localparam int RP = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] key_n = '1;
    logic [W-1:0] key_level;
    logic [W-1:0] key_press;
    logic [W-1:0] key_release;
    logic any_press;

    key_debounce_pulse #(
        .KEY_WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_n(key_n),
        .key_level(key_level),
        .key_press(key_press),
        .key_release(key_release),
        .any_press(any_press)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Model: a key change is accepted once the 2-cycle-delayed key has differed
    // from the accepted level on D+1 consecutive edges.
    logic [W-1:0] m_d1, m_d2, m_level, m_press, m_rel;
    int m_run[W];
    int m_ticks[W];

    logic [W-1:0] seen_press, seen_rel;
    int any_cnt;

    typedef struct {
        logic [W-1:0] key_n;
        int hold;
        logic [W-1:0] level;
        logic [W-1:0] press;
        logic [W-1:0] rel;
        int any;
    } vec_t;
    vec_t vt[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_d1 = '1;
        m_d2 = '1;
        m_level = '0;
        m_press = '0;
        m_rel = '0;
        for (int i = 0; i < W; i++) begin
            m_run[i] = 0;
            m_ticks[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < W; i++) begin
            logic s;
`ifdef AUTO_REPEAT_EN
            logic held;
            held = m_level[i] && m_run[i] == 0;
`endif
            s = ~m_d2[i];
            m_d2[i] = m_d1[i];
            m_d1[i] = key_n[i];
            m_press[i] = 1'b0;
            m_rel[i] = 1'b0;
            if (s != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == D + 1) begin
                    m_level[i] = s;
                    m_run[i] = 0;
                    m_ticks[i] = 0;
                    if (s) m_press[i] = 1'b1;
                    else m_rel[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
`ifdef AUTO_REPEAT_EN
                if (held && s) begin
                    m_ticks[i]++;
                    if (m_ticks[i] >= RD && (m_ticks[i] - RD) % RP == 0) m_press[i] = 1'b1;
                end
`endif
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        #2;
        check("cycle_model", {key_level, key_press, key_release, any_press},
              {m_level, m_press, m_rel, |m_press});
        check("press_release_exclusive", key_press & key_release, 0);
        seen_press |= key_press;
        seen_rel |= key_release;
        if (any_press) any_cnt++;
    endtask

    task automatic clear_acc();
        seen_press = '0;
        seen_rel = '0;
        any_cnt = 0;
    endtask

    task automatic hold(input logic [W-1:0] k, input int n);
        key_n = k;
        for (int c = 0; c < n; c++) tick();
    endtask

    initial begin
        int got_q[$];
        int exp_q[$];
        int pcnt;
        int waited;
        model_reset();
        clear_acc();
        vt[0] = '{4'hF, 5, 4'h0, 4'h0, 4'h0, 0};
        vt[1] = '{4'hE, 15, 4'h1, 4'h1, 4'h0, 1};
        vt[2] = '{4'hF, 15, 4'h0, 4'h0, 4'h1, 0};
        vt[3] = '{4'h0, 15, 4'hF, 4'hF, 4'h0, 1};
        vt[4] = '{4'hF, 15, 4'h0, 4'h0, 4'hF, 0};
        vt[5] = '{4'h5, 15, 4'hA, 4'hA, 4'h0, 1};
        vt[6] = '{4'hF, 6, 4'hA, 4'h0, 4'h0, 0};
        vt[7] = '{4'hF, 10, 4'h0, 4'h0, 4'hA, 0};
        vt[8] = '{4'hB, 6, 4'h0, 4'h0, 4'h0, 0};
        vt[9] = '{4'hF, 12, 4'h0, 4'h0, 4'h0, 0};

        repeat (3) @(posedge clk);
        #2;
        check("reset_state", {key_level, key_press, key_release, any_press}, 0);
        rst = 1'b0;

        for (int r = 0; r < 10; r++) begin
            clear_acc();
            hold(vt[r].key_n, vt[r].hold);
            check($sformatf("vec%0d_level", r), key_level, vt[r].level);
            check($sformatf("vec%0d_press", r), seen_press, vt[r].press);
            check($sformatf("vec%0d_release", r), seen_rel, vt[r].rel);
            check($sformatf("vec%0d_any_cnt", r), any_cnt, vt[r].any);
        end

        // Clean press latency: pulse exactly after edge D+3.
        key_n = 4'hE;
        for (int e = 1; e <= 13; e++) begin
            tick();
            check($sformatf("press_lat_e%0d", e), key_press[0], e == D + 3);
            check($sformatf("level_lat_e%0d", e), key_level[0], e >= D + 3);
        end
        hold(4'hF, 12);

        // Bounce every 3 cycles on key 1, then a real press.
        clear_acc();
        for (int c = 0; c < 30; c++) begin
            key_n = {2'b11, ((c / 3) % 2 == 0) ? 1'b0 : 1'b1, 1'b1};
            tick();
        end
        check("bounce_no_press", seen_press, 0);
        check("bounce_level", key_level[1], 0);
        pcnt = 0;
        key_n = 4'hD;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (key_press[1]) pcnt++;
        end
        check("bounce_then_press_cnt", pcnt, 1);
        hold(4'hF, 12);

        // Release with a 2-cycle low bounce on key 2.
        hold(4'hB, 12);
        check("rel_bounce_held", key_level[2], 1);
        clear_acc();
        hold(4'hF, 4);
        hold(4'hB, 2);
        check("rel_bounce_no_release", seen_rel, 0);
        key_n = 4'hF;
        for (int j = 1; j <= 13; j++) begin
            tick();
            check($sformatf("rel_lat_j%0d", j), key_release[2], j == D + 3);
            check($sformatf("rel_level_j%0d", j), key_level[2], j < D + 3);
        end

        // Simultaneous presses: one any_press cycle.
        clear_acc();
        pcnt = 0;
        key_n = 4'h0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (key_press == 4'hF) pcnt++;
        end
        check("simul_press_all", pcnt, 1);
        check("simul_any_cnt", any_cnt, 1);
        hold(4'hF, 12);

        // Held key: auto-repeat schedule relative to acceptance.
        key_n = 4'hE;
        waited = 0;
        while (!key_press[0] && waited < 20) begin
            tick();
            waited++;
        end
        check("repeat_accept_seen", key_press[0], 1);
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (key_press[0]) got_q.push_back(k);
        end
`ifdef AUTO_REPEAT_EN
        exp_q = '{20, 26, 32, 38, 44, 50};
`endif
        check("repeat_count", got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check($sformatf("repeat_pos%0d", k), got_q[k], exp_q[k]);
        hold(4'hF, 12);

        // Async reset while key 3 is held, then re-debounce.
        hold(4'h7, 12);
        check("pre_reset_level", key_level[3], 1);
        rst = 1'b1;
        #1;
        check("async_reset_clear", {key_level, key_press, key_release, any_press}, 0);
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        for (int j = 1; j <= 13; j++) begin
            tick();
            check($sformatf("post_reset_press_j%0d", j), key_press[3], j == D + 3);
        end
        hold(4'hF, 12);

        // Random key activity against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(14) == 0) key_n[i] = ~key_n[i];
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
